// File: rtl/hs32_mdu_seq.sv
// hs32_mdu_seq -- multi-cycle unsigned multiply / divide sequencer.
//
// Shares the hs32 ALU adder with the execute stage. It does one
// shift-add (MULU) or one restoring-divide (DIVU) step per cycle in which
// the core's ALU mux grants it the adder. All 32 steps of an operation run
// through the ALU. Architectural flags are never written (fwe/cen stay 0).
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   req_valid_i/_ready_o, op_i (0=MULU,1=DIVU), opa_i, opb_i : request
//   resp_valid_o/_ready_i, resp_lo_o (prod lo / quot), resp_hi_o (prod hi / rem)
//   busy_o            sequencer is not idle
//   alu_req_o/alu_gnt_i  ALU borrow handshake
//   alu_a_o, alu_b_o, alu_ctl_o  operands and control presented to the ALU
//   alu_out_i         combinational ALU result

package hs32_mdu_pkg;
  typedef struct packed {
    logic       fwe;   // flag write enable
    logic       cen;   // carry-in enable
    logic [1:0] opr;   // operation select, 00 = adder
    logic       neg;   // invert b
    logic       sub;   // subtract (a - b)
  } hs32_aluctl;
endpackage

module hs32_mdu_seq
  import hs32_mdu_pkg::*;
#(
  parameter logic [31:0] DIV0_Q = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        op_i,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_lo_o,
  output logic [31:0] resp_hi_o,
  output logic        busy_o,
  output logic        alu_req_o,
  input  logic        alu_gnt_i,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output hs32_aluctl  alu_ctl_o,
  input  logic [31:0] alu_out_i
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] opnd_q, opnd_d;   // multiplicand (MUL) or divisor (DIV)
  logic [4:0]  cnt_q, cnt_d;

  // ---------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------
  logic [31:0] rs;        // partial remainder shifted left by one
  logic        mul_c;     // adder carry-out, rebuilt from the MSBs
  logic        div_m;     // bit shifted out of hi: remainder >= 2^32
  logic        div_nb;    // no borrow: rs >= divisor

  assign rs    = {hi_q[30:0], lo_q[31]};
  assign div_m = hi_q[31];

  // The ALU only returns a 32-bit sum, so carry / borrow are recovered
  // from the operand MSBs and the result MSB.
  assign mul_c  = (hi_q[31] & opnd_q[31]) |
                  ((hi_q[31] | opnd_q[31]) & ~alu_out_i[31]);
  assign div_nb = (rs[31] & ~opnd_q[31]) |
                  ((rs[31] | ~opnd_q[31]) & ~alu_out_i[31]);

  localparam hs32_aluctl CTL_ADD = '{fwe: 1'b0, cen: 1'b0, opr: 2'b00,
                                     neg: 1'b0, sub: 1'b0};
  localparam hs32_aluctl CTL_SUB = '{fwe: 1'b0, cen: 1'b0, opr: 2'b00,
                                     neg: 1'b1, sub: 1'b1};

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    opnd_d       = opnd_q;
    cnt_d        = cnt_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_lo_o    = '0;
    resp_hi_o    = '0;
    alu_req_o    = 1'b0;
    alu_a_o      = hi_q;
    alu_b_o      = opnd_q;
    alu_ctl_o    = CTL_ADD;

    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          cnt_d = '0;
          if (!op_i) begin
            hi_d    = '0;
            lo_d    = opb_i;
            opnd_d  = opa_i;
            state_d = MUL;
          end else if (opb_i != '0) begin
            hi_d    = '0;
            lo_d    = opa_i;
            opnd_d  = opb_i;
            state_d = DIV;
          end else begin
            // Divide by zero needs no iterations: answer right away.
            hi_d    = opa_i;
            lo_d    = DIV0_Q;
            opnd_d  = opb_i;
            state_d = DONE;
          end
        end
      end

      MUL: begin
        alu_req_o = 1'b1;
        alu_a_o   = hi_q;
        alu_ctl_o = CTL_ADD;
        if (alu_gnt_i) begin
          if (lo_q[0]) begin
            hi_d = {mul_c, alu_out_i[31:1]};
            lo_d = {alu_out_i[0], lo_q[31:1]};
          end else begin
            hi_d = {1'b0, hi_q[31:1]};
            lo_d = {hi_q[0], lo_q[31:1]};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = DONE;
        end
      end

      DIV: begin
        alu_req_o = 1'b1;
        alu_a_o   = rs;
        alu_ctl_o = CTL_SUB;
        if (alu_gnt_i) begin
          // With div_m set the true remainder is 33 bits wide and always
          // exceeds the divisor; the truncated difference is still exact.
          if (div_m | div_nb) begin
            hi_d = alu_out_i;
            lo_d = {lo_q[30:0], 1'b1};
          end else begin
            hi_d = rs;
            lo_d = {lo_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = DONE;
        end
      end

      DONE: begin
        resp_valid_o = 1'b1;
        resp_lo_o    = lo_q;
        resp_hi_o    = hi_q;
        if (resp_ready_i) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_hs32_mdu_seq.sv
// Bench for hs32_mdu_seq: directed cases plus random MULU/DIVU traffic,
// with a simple ALU model on the borrow port and an arithmetic reference.
module tb_hs32_mdu_seq;
  import hs32_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, op;
  logic [31:0] opa, opb;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_lo, resp_hi;
  logic        busy, alu_req, alu_gnt;
  logic [31:0] alu_a, alu_b, alu_out;
  hs32_aluctl  alu_ctl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Shared adder: a + b, or a - b when sub is set.
  assign alu_out = alu_ctl.sub ? (alu_a - alu_b) : (alu_a + alu_b);

  hs32_mdu_seq dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .op_i(op), .opa_i(opa), .opb_i(opb),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_lo_o(resp_lo), .resp_hi_o(resp_hi),
    .busy_o(busy),
    .alu_req_o(alu_req), .alu_gnt_i(alu_gnt),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_ctl_o(alu_ctl),
    .alu_out_i(alu_out)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result {hi, lo}.
  function automatic logic [63:0] model(input logic o, input logic [31:0] a,
                                        input logic [31:0] b);
    if (!o)             return 64'(a) * 64'(b);
    else if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    else                return {a % b, a / b};
  endfunction

  // gmode: 0 = grant always, 1 = grant 0,1,0,1.., 2 = random grant
  task automatic run_op(input logic o, input logic [31:0] a,
                        input logic [31:0] b, input int gmode,
                        input int stall);
    logic [63:0] exp;
    hs32_aluctl  ectl;
    int n, grants;
    bit saw_req, div0;
    exp  = model(o, a, b);
    div0 = o && (b == 32'd0);
    ectl = '0;
    if (o) begin ectl.neg = 1'b1; ectl.sub = 1'b1; end
    chk("ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; op = o; opa = a; opb = b;
    alu_gnt = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("busy_run", 64'(busy), 64'd1);
    chk("ready_run", 64'(req_ready), 64'd0);
    if (!div0) chk("alu_ctl", 64'(alu_ctl), 64'(ectl));
    n = 0; grants = 0; saw_req = 1'b0;
    while (!resp_valid && n < 400) begin
      case (gmode)
        0:       alu_gnt = 1'b1;
        1:       alu_gnt = (n % 2 == 1);
        default: alu_gnt = 1'($urandom % 2);
      endcase
      if (alu_req) saw_req = 1'b1;
      if (alu_req && alu_gnt) grants++;
      @(posedge clk); #1;
      n++;
    end
    alu_gnt = 1'b0;
    chk("resp_valid", 64'(resp_valid), 64'd1);
    chk("resp_lo", 64'(resp_lo), 64'(exp[31:0]));
    chk("resp_hi", 64'(resp_hi), 64'(exp[63:32]));
    chk("ctl_done", 64'(alu_ctl), 64'd0);
    if (div0) begin
      chk("div0_lat", 64'(n), 64'd0);
      chk("div0_noreq", 64'(saw_req), 64'd0);
    end else begin
      chk("grants", 64'(grants), 64'd32);
      if (gmode == 0) chk("lat_g1", 64'(n), 64'd32);
      if (gmode == 1) chk("lat_tog", 64'(n), 64'd64);
    end
    // Back-pressure: result must hold, new requests must be ignored.
    repeat (stall) begin
      req_valid = 1'b1; op = 1'b0; opa = $urandom; opb = $urandom;
      alu_gnt = 1'b1;
      @(posedge clk); #1;
      chk("stall_valid", 64'(resp_valid), 64'd1);
      chk("stall_lo", 64'(resp_lo), 64'(exp[31:0]));
      chk("stall_hi", 64'(resp_hi), 64'(exp[63:32]));
      chk("stall_rdy", 64'(req_ready), 64'd0);
      chk("stall_areq", 64'(alu_req), 64'd0);
    end
    alu_gnt = 1'b0;
    // Consume; a request held high here must not be taken this cycle.
    req_valid = 1'b1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid = 1'b0;
    chk("post_valid", 64'(resp_valid), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_ready", 64'(req_ready), 64'd1);
  endtask

  initial begin
    logic        ro;
    logic [31:0] ra, rb;
    reset = 1'b1; req_valid = 1'b0; op = 1'b0; opa = '0; opb = '0;
    resp_ready = 1'b0; alu_gnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_areq", 64'(alu_req), 64'd0);
    chk("rst_lo", 64'(resp_lo), 64'd0);
    chk("rst_hi", 64'(resp_hi), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(1'b0, 32'd7, 32'd6, 0, 0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(1'b1, 32'd100, 32'd7, 0, 5);
    run_op(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 0, 0);
    run_op(1'b1, 32'd5, 32'd0, 0, 2);
    run_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1, 0);
    run_op(1'b1, 32'hDEAD_BEEF, 32'd1, 1, 0);

    // Reset in the middle of a multiply: no response, idle next cycle.
    req_valid = 1'b1; op = 1'b0; opa = 32'd3; opb = 32'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    alu_gnt = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    alu_gnt = 1'b0;
    chk("abort_valid", 64'(resp_valid), 64'd0);
    chk("abort_ready", 64'(req_ready), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_areq", 64'(alu_req), 64'd0);
    repeat (40) begin
      alu_gnt = 1'b1;
      @(posedge clk); #1;
      chk("abort_quiet", 64'(resp_valid), 64'd0);
    end
    alu_gnt = 1'b0;

    for (int i = 0; i < 24; i++) begin
      ro = 1'($urandom % 2);
      ra = $urandom;
      case ($urandom % 4)
        0:       rb = 32'd0;
        1:       rb = $urandom % 256;
        default: rb = $urandom;
      endcase
      if ($urandom % 3 == 0) ra = ra >> ($urandom % 32);
      run_op(ro, ra, rb, int'($urandom % 3), int'($urandom % 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
